huffman_decoder: RTL

Serial Huffman decoder: the receive-side counterpart of the six-symbol Huffman code builder. A load strobe captures a code table of six 8-bit codes and six 8-bit masks, i.e. HC1–HC6 and M1–M6 as produced by the encoder path. The block then accepts one code bit per valid/ready handshake, MSB of each codeword first, and emits the 1-based symbol index (1..6) on a valid/ready output. Unmatched 8-bit prefixes raise a sticky error.

---
 rtl/huffman_decoder_if.sv | 33 +++
 rtl/huffman_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_decoder_if
//  Description : Bundle of the huffman_decoder table-load, bit-input and
//                symbol-output handshake signals.
//                master : table/bit producer and symbol consumer
//                slave  : the decoder
//  Revision    : 1.0 - initial release
// ============================================================================
interface huffman_decoder_if;
  logic        load;       // single-cycle table capture strobe
  logic [47:0] hc_table;   // {HC6..HC1}, codes right-justified
  logic [47:0] m_table;    // {M6..M1}, 2^L-1 per entry, 0 = unused
  logic        bit_in;     // code bit, MSB of codeword first
  logic        bit_valid;  // bit_in valid
  logic        bit_ready;  // decoder accepts a bit this cycle
  logic [2:0]  sym_out;    // decoded symbol 1..6
  logic        sym_valid;  // sym_out valid
  logic        sym_ready;  // consumer accepts sym_out
  logic [7:0]  sym_cnt;    // symbols handed off, wraps
  logic        err;        // sticky no-match error

  modport master (
    output load, hc_table, m_table, bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_valid, sym_cnt, err
  );

  modport slave (
    input  load, hc_table, m_table, bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_valid, sym_cnt, err
  );
endinterface
`default_nettype wire

// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_decoder
//  Description : Serial six-entry Huffman decoder. A load strobe captures the
//                code/mask table; code bits are then shifted in one per
//                handshake and each recognised codeword is emitted as a
//                1-based symbol index. An 8-bit prefix that matches nothing
//                raises a sticky error until the next load or reset.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - huffman_decoder_if.slave (table, bit and symbol I/O)
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_decoder (
  input  wire logic          clk,
  input  wire logic          rst_n,
  huffman_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_EMIT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [47:0] r_hc, w_hc_nxt;
  logic [47:0] r_m, w_m_nxt;
  logic [7:0]  r_acc, w_acc_nxt;
  logic [3:0]  r_len, w_len_nxt;
  logic [2:0]  r_sym, w_sym_nxt;
  logic        r_sym_valid, w_sym_valid_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;

  // Candidate accumulator/length if the current bit is accepted.
  logic [7:0]  w_acc_shift;
  logic [3:0]  w_len_inc;
  logic [8:0]  w_mask_full;
  logic [7:0]  w_len_mask;
  logic [5:0]  w_match;
  logic [2:0]  w_match_sym;
  logic        w_any_match;

  assign w_acc_shift = {r_acc[6:0], bus.bit_in};
  assign w_len_inc   = r_len + 4'd1;
  // Length never exceeds 8 here, so 9 bits hold 2^len-1 without overflow.
  assign w_mask_full = (9'd1 << w_len_inc) - 9'd1;
  assign w_len_mask  = w_mask_full[7:0];

  // An entry matches only when its code length equals the bits seen so far;
  // requiring the exact mask prevents a short code matching a longer prefix.
  generate
    for (genvar k = 0; k < 6; k++) begin : g_match
      assign w_match[k] = (r_m[8*k +: 8] != 8'd0) &&
                          (r_m[8*k +: 8] == w_len_mask) &&
                          ((w_acc_shift & r_m[8*k +: 8]) == r_hc[8*k +: 8]);
    end
  endgenerate

  // Scan high to low so the lowest matching entry is the one left standing.
  always_comb begin
    w_match_sym = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (w_match[k]) w_match_sym = 3'(k + 1);
    end
  end

  assign w_any_match = |w_match;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hc        <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_len       <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hc        <= w_hc_nxt;
      r_m         <= w_m_nxt;
      r_acc       <= w_acc_nxt;
      r_len       <= w_len_nxt;
      r_sym       <= w_sym_nxt;
      r_sym_valid <= w_sym_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_hc_nxt        = r_hc;
    w_m_nxt         = r_m;
    w_acc_nxt       = r_acc;
    w_len_nxt       = r_len;
    w_sym_nxt       = r_sym;
    w_sym_valid_nxt = r_sym_valid;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;

    if (bus.load) begin
      // Load overrides everything: a bit presented alongside it is ignored
      // and any pending symbol is dropped without being counted.
      w_hc_nxt        = bus.hc_table;
      w_m_nxt         = bus.m_table;
      w_acc_nxt       = '0;
      w_len_nxt       = '0;
      w_sym_nxt       = '0;
      w_sym_valid_nxt = 1'b0;
      w_err_nxt       = 1'b0;
      w_state_nxt     = S_SHIFT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_SHIFT: begin
          if (bus.bit_valid) begin
            if (w_any_match) begin
              w_sym_nxt       = w_match_sym;
              w_sym_valid_nxt = 1'b1;
              w_acc_nxt       = '0;
              w_len_nxt       = '0;
              w_state_nxt     = S_EMIT;
            end else if (w_len_inc == 4'd8) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_ERR;
            end else begin
              w_acc_nxt = w_acc_shift;
              w_len_nxt = w_len_inc;
            end
          end
        end
        S_EMIT: begin
          if (r_sym_valid && bus.sym_ready) begin
            w_sym_valid_nxt = 1'b0;
            w_cnt_nxt       = r_cnt + 8'd1;
            w_state_nxt     = S_SHIFT;
          end
        end
        S_ERR: begin
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // bit_ready depends on the registered state only.
  assign bus.bit_ready = (r_state == S_SHIFT);
  assign bus.sym_out   = r_sym;
  assign bus.sym_valid = r_sym_valid;
  assign bus.sym_cnt   = r_cnt;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
